// File: rtl/replacement_policy.sv
// Victim-way selector for a set-associative cache: true LRU, FIFO or LFSR pseudo-random,
// with a one-deep registered victim output under valid/ready handshake.
module replacement_policy #(
  parameter int unsigned N_WAYS = 4,
  parameter int unsigned N_SETS = 8,
  parameter int unsigned MODE   = 0,
  localparam int unsigned WAY_W = $clog2(N_WAYS),
  localparam int unsigned SET_W = (N_SETS > 1) ? $clog2(N_SETS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SET_W-1:0]  req_set,
  input  logic [N_WAYS-1:0] line_empty,
  output logic              evict_valid,
  input  logic              evict_ready,
  output logic [WAY_W-1:0]  evict_way,
  input  logic              acc_valid,
  input  logic [SET_W-1:0]  acc_set,
  input  logic [WAY_W-1:0]  acc_way,
  input  logic              acc_fill
);

  logic              accept;
  logic              empty_any;
  logic [WAY_W-1:0]  empty_way;
  logic [WAY_W-1:0]  mode_way;
  logic [WAY_W-1:0]  victim;
  logic [SET_W-1:0]  q_set;
  logic [SET_W-1:0]  a_set;
  logic              evict_valid_q;
  logic [WAY_W-1:0]  evict_way_q;

  // A single-set configuration still carries a 1-bit index; force it to entry 0.
  assign q_set = (N_SETS > 1) ? req_set : '0;
  assign a_set = (N_SETS > 1) ? acc_set : '0;

  assign req_ready   = !evict_valid_q || evict_ready;
  assign accept      = req_valid && req_ready;
  assign evict_valid = evict_valid_q;
  assign evict_way   = evict_way_q;

  always_comb begin
    empty_any = |line_empty;
    empty_way = '0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (line_empty[w]) empty_way = WAY_W'(w);
    end
    victim = empty_any ? empty_way : mode_way;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evict_valid_q <= 1'b0;
      evict_way_q   <= '0;
    end else if (accept) begin
      evict_valid_q <= 1'b1;
      evict_way_q   <= victim;
    end else if (evict_ready) begin
      evict_valid_q <= 1'b0;
    end
  end

  if (MODE == 0) begin : g_lru
    logic [WAY_W-1:0] rank_q [N_SETS][N_WAYS];
    logic             unused_lru;

    assign unused_lru = acc_fill;

    always_comb begin
      mode_way = '0;
      for (int w = 0; w < N_WAYS; w++) begin
        if (rank_q[q_set][w] == WAY_W'(N_WAYS - 1)) mode_way = WAY_W'(w);
      end
    end

    // Ways younger than the accessed one age by one; the rest keep their rank.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < N_SETS; s++) begin
          for (int w = 0; w < N_WAYS; w++) rank_q[s][w] <= WAY_W'(w);
        end
      end else if (acc_valid) begin
        for (int w = 0; w < N_WAYS; w++) begin
          if (WAY_W'(w) == acc_way) begin
            rank_q[a_set][w] <= '0;
          end else if (rank_q[a_set][w] < rank_q[a_set][acc_way]) begin
            rank_q[a_set][w] <= rank_q[a_set][w] + WAY_W'(1);
          end
        end
      end
    end
  end else if (MODE == 1) begin : g_fifo
    logic [WAY_W-1:0] ptr_q [N_SETS];

    assign mode_way = ptr_q[q_set];

    // Power-of-two way count lets the pointer wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < N_SETS; s++) ptr_q[s] <= '0;
      end else if (acc_valid && acc_fill && (acc_way == ptr_q[a_set])) begin
        ptr_q[a_set] <= ptr_q[a_set] + WAY_W'(1);
      end
    end
  end else if (MODE == 2) begin : g_rand
    logic [15:0] lfsr_q;
    logic        unused_rand;

    assign mode_way    = lfsr_q[WAY_W-1:0];
    assign unused_rand = ^{acc_valid, acc_fill, acc_way, a_set, q_set, lfsr_q[15:WAY_W]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lfsr_q <= 16'hACE1;
      end else begin
        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
    end
  end else begin : g_bad_mode
    $error("replacement_policy: MODE must be 0, 1 or 2");
  end

endmodule

// File: tb/tb_replacement_policy.sv
// Drives LRU, FIFO and random instances with shared stimulus; a scoreboard per instance
// checks every victim the DUTs hand over.
module tb_replacement_policy;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid, evict_ready, acc_valid, acc_fill;
  logic [2:0] req_set, acc_set;
  logic [3:0] line_empty;
  logic [1:0] acc_way;
  logic       rr_l, rr_f, rr_r, ev_l, ev_f, ev_r;
  logic [1:0] ew_l, ew_f, ew_r;

  always #5 clk = ~clk;

  replacement_policy #(.N_WAYS(4), .N_SETS(8), .MODE(0)) u_lru (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_l), .req_set(req_set),
    .line_empty(line_empty), .evict_valid(ev_l), .evict_ready(evict_ready), .evict_way(ew_l),
    .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way), .acc_fill(acc_fill));
  replacement_policy #(.N_WAYS(4), .N_SETS(8), .MODE(1)) u_fifo (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_f), .req_set(req_set),
    .line_empty(line_empty), .evict_valid(ev_f), .evict_ready(evict_ready), .evict_way(ew_f),
    .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way), .acc_fill(acc_fill));
  replacement_policy #(.N_WAYS(4), .N_SETS(8), .MODE(2)) u_rnd (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_r), .req_set(req_set),
    .line_empty(line_empty), .evict_valid(ev_r), .evict_ready(evict_ready), .evict_way(ew_r),
    .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way), .acc_fill(acc_fill));

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  q_l[$];
  logic [1:0]  q_f[$];
  logic [1:0]  q_r[$];
  logic [1:0]  exp_l, exp_f;
  logic [15:0] m_lfsr;
  logic [1:0]  lru_seq [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR: taps 16,14,13,11, seeded 16'hACE1.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Expected victims are queued at the accepting edge.
  always @(posedge clk) begin
    if (!rst && req_valid && rr_l) begin
      q_l.push_back(exp_l);
      q_f.push_back(exp_f);
      q_r.push_back((line_empty != 4'b0) ? exp_l : m_lfsr[1:0]);
    end
  end

  // Monitor: each victim is checked once, in the cycle it is consumed.
  always @(negedge clk) begin
    if (!rst && evict_ready) begin
      if (ev_l) begin
        if (q_l.size() == 0) chk("lru unexpected response", 1, 0);
        else chk("lru victim", ew_l, q_l.pop_front());
      end
      if (ev_f) begin
        if (q_f.size() == 0) chk("fifo unexpected response", 1, 0);
        else chk("fifo victim", ew_f, q_f.pop_front());
      end
      if (ev_r) begin
        if (q_r.size() == 0) chk("rnd unexpected response", 1, 0);
        else chk("rnd victim", ew_r, q_r.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input logic [2:0] s, input logic [3:0] e, input logic [1:0] el,
                       input logic [1:0] ef);
    int n = 0;
    bit rdy;
    req_valid = 1'b1; req_set = s; line_empty = e; exp_l = el; exp_f = ef;
    do begin
      @(negedge clk);
      rdy = rr_l;
      cyc();
      n++;
    end while (!rdy && n < 20);
    if (!rdy) chk("query accept timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic acc(input logic [2:0] s, input logic [1:0] w, input logic f);
    acc_valid = 1'b1; acc_set = s; acc_way = w; acc_fill = f;
    cyc();
    acc_valid = 1'b0;
  endtask

  initial begin
    lru_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    evict_ready = 1'b1;
    req_set = 3'd3; line_empty = 4'b0; exp_l = 2'd0; exp_f = 2'd0;
    // Traffic during reset must be ignored (a fill at way 0 would move set 3's FIFO pointer).
    req_valid = 1'b1;
    acc_valid = 1'b1; acc_set = 3'd3; acc_way = 2'd0; acc_fill = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset lru evict_valid", ev_l, 0);
    chk("reset fifo evict_valid", ev_f, 0);
    chk("reset rnd evict_valid", ev_r, 0);
    chk("reset lru evict_way", ew_l, 0);
    chk("reset fifo evict_way", ew_f, 0);
    chk("reset rnd evict_way", ew_r, 0);
    req_valid = 1'b0; acc_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // Basic LRU after reset, then accesses 3,1 to set 3.
    query(3'd3, 4'b0000, 2'd3, 2'd0);
    acc(3'd3, 2'd3, 1'b1);
    acc(3'd3, 2'd1, 1'b0);
    query(3'd3, 4'b0000, 2'd2, 2'd0);

    // Empty ways take priority in every mode.
    query(3'd2, 4'b1010, 2'd1, 2'd1);
    query(3'd2, 4'b1000, 2'd3, 2'd3);

    // FIFO pointer walk on set 0 with fills at the pointer.
    for (int i = 0; i < 5; i++) begin
      query(3'd0, 4'b0000, lru_seq[i], 2'(i % 4));
      acc(3'd0, 2'(i % 4), 1'b1);
    end
    acc(3'd0, 2'd1, 1'b0);
    query(3'd0, 4'b0000, 2'd2, 2'd1);
    acc(3'd0, 2'd3, 1'b1);
    query(3'd0, 4'b0000, 2'd2, 2'd1);

    // Same-edge query and access to fresh set 5: victim from pre-update state.
    acc_valid = 1'b1; acc_set = 3'd5; acc_way = 2'd3; acc_fill = 1'b0;
    query(3'd5, 4'b0000, 2'd3, 2'd0);
    acc_valid = 1'b0;
    query(3'd5, 4'b0000, 2'd2, 2'd0);
    cyc(); cyc();

    // Backpressure: victim holds and req_ready drops while evict_ready is low.
    evict_ready = 1'b0;
    query(3'd6, 4'b0100, 2'd2, 2'd2);
    req_valid = 1'b1; req_set = 3'd6; line_empty = 4'b0001; exp_l = 2'd0; exp_f = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall evict_valid", ev_l, 1);
      chk("stall lru way", ew_l, 2);
      chk("stall fifo way", ew_f, 2);
      chk("stall rnd way", ew_r, 2);
      chk("stall req_ready", rr_l, 0);
      cyc();
    end
    evict_ready = 1'b1;
    query(3'd6, 4'b0001, 2'd0, 2'd0);
    @(negedge clk);
    chk("back-to-back evict_valid", ev_l, 1);
    chk("back-to-back evict_way", ew_l, 0);
    cyc(); cyc();

    // Reset while a victim is pending drops it; state returns to reset values.
    evict_ready = 1'b0;
    query(3'd7, 4'b0000, 2'd3, 2'd0);
    @(negedge clk);
    chk("pending before reset", ev_l, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset drops lru pending", ev_l, 0);
    chk("reset drops fifo pending", ev_f, 0);
    chk("reset drops rnd pending", ev_r, 0);
    q_l.delete(); q_f.delete(); q_r.delete();
    evict_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    query(3'd0, 4'b0000, 2'd3, 2'd0);
    query(3'd3, 4'b0000, 2'd3, 2'd0);

    repeat (4) cyc();
    chk("scoreboard drained", q_l.size() + q_f.size() + q_r.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
